// File: rtl/end_banner_renderer.sv
// end_banner_renderer: places the "YOU WIN" banner on the 640x480 raster,
// converts raster coordinates into glyph-map coordinates, and runs the
// per-frame slide-in / hold / blink animation. The pixel outputs are
// registered, giving one clock of latency from DrawX/DrawY.
module end_banner_renderer #(
    parameter int BANNER_X    = 296,
    parameter int TARGET_Y    = 208,
    parameter int SCALE_LOG2  = 1,
    parameter int SLIDE_STEP  = 4,
    parameter int HOLD_FRAMES = 60,
    parameter int BLINK_HALF  = 15
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       game_won,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [5:0] text_X,
    output logic [4:0] text_Y,
    input  logic       text_pixel,
    output logic       banner_on,
    output logic       banner_pixel
);

    // All geometry is done in 11 bits so that edge sums never wrap.
    localparam logic [10:0] BX         = 11'(BANNER_X);
    localparam logic [10:0] BANNER_W   = 11'(24 << SCALE_LOG2);
    localparam logic [10:0] BANNER_H   = 11'(32 << SCALE_LOG2);
    localparam logic [10:0] BX_END     = BX + BANNER_W;
    localparam logic [10:0] TY         = 11'(TARGET_Y);
    localparam logic [10:0] STEP       = 11'(SLIDE_STEP);
    localparam logic [15:0] HOLD_LAST  = 16'(HOLD_FRAMES - 1);
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        ST_HIDDEN,
        ST_SLIDE,
        ST_HOLD,
        ST_BLINK
    } state_t;

    state_t      state_q;
    logic [10:0] banner_y_q;
    logic [15:0] frame_cnt_q;
    logic        blink_vis_q;
    logic        visible_q;
    logic        frame_q;

    logic        frame_tick;
    logic [10:0] slide_sum;
    logic [10:0] slide_next;

    assign frame_tick = frame_clk & ~frame_q;
    assign slide_sum  = banner_y_q + STEP;
    assign slide_next = (slide_sum >= TY) ? TY : slide_sum;

    // Delayed copy of frame_clk for rising-edge detection.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_q <= 1'b0;
        end else begin
            frame_q <= frame_clk;
        end
    end

    // Animation FSM; visible_q is kept in step with the state so it is a registered output.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_HIDDEN;
            banner_y_q  <= '0;
            frame_cnt_q <= '0;
            blink_vis_q <= 1'b0;
            visible_q   <= 1'b0;
        end else if (!game_won) begin
            // Leaving the win screen wins over any coincident frame tick.
            state_q     <= ST_HIDDEN;
            banner_y_q  <= '0;
            frame_cnt_q <= '0;
            blink_vis_q <= 1'b0;
            visible_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_HIDDEN: begin
                    state_q     <= ST_SLIDE;
                    banner_y_q  <= '0;
                    frame_cnt_q <= '0;
                    visible_q   <= 1'b1;
                end
                ST_SLIDE: begin
                    if (frame_tick) begin
                        banner_y_q <= slide_next;
                        if (slide_next == TY) begin
                            state_q     <= ST_HOLD;
                            frame_cnt_q <= '0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (frame_tick) begin
                        if (frame_cnt_q == HOLD_LAST) begin
                            state_q     <= ST_BLINK;
                            frame_cnt_q <= '0;
                            blink_vis_q <= 1'b1;
                            visible_q   <= 1'b1;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                        end
                    end
                end
                ST_BLINK: begin
                    if (frame_tick) begin
                        if (frame_cnt_q == BLINK_LAST) begin
                            blink_vis_q <= ~blink_vis_q;
                            visible_q   <= ~blink_vis_q;
                            frame_cnt_q <= '0;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_HIDDEN;
                    visible_q <= 1'b0;
                end
            endcase
        end
    end

    logic [10:0] dx;
    logic [10:0] dy;
    logic [10:0] x_off;
    logic [10:0] y_off;
    logic        in_win;

    assign dx     = {1'b0, DrawX};
    assign dy     = {1'b0, DrawY};
    assign x_off  = dx - BX;
    assign y_off  = dy - banner_y_q;
    assign in_win = (dx >= BX) && (dx < BX_END) &&
                    (dy >= banner_y_q) && (dy < banner_y_q + BANNER_H);

    // Local glyph coordinates; forced to 0 outside the window so the map never sees out-of-range values.
    always_comb begin
        text_X = '0;
        text_Y = '0;
        if (in_win) begin
            text_X = 6'(x_off >> SCALE_LOG2);
            text_Y = 5'(y_off >> SCALE_LOG2);
        end
    end

    // Registered pixel outputs to the colour mapper.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            banner_on    <= 1'b0;
            banner_pixel <= 1'b0;
        end else begin
            banner_on    <= in_win & visible_q;
            banner_pixel <= in_win & visible_q & text_pixel;
        end
    end

endmodule

// File: tb/tb_end_banner_renderer.sv
// Directed bench for end_banner_renderer: reset, slide-in (two step sizes),
// glyph coordinate mapping, window edges, hold/blink timing, game_won drop and
// mid-animation reset.
module tb_end_banner_renderer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic       game_won;
    logic [9:0] DrawX;
    logic [9:0] DrawY;

    logic [5:0] tx_a, tx_b;
    logic [4:0] ty_a, ty_b;
    logic       tp_a, tp_b;
    logic       on_a, on_b;
    logic       pix_a, pix_b;

    int compared   = 0;
    int mismatched = 0;

    always #5 Clk = ~Clk;

    // Stub glyph maps: checkerboard of local coordinates.
    assign tp_a = tx_a[0] ^ ty_a[0];
    assign tp_b = tx_b[0] ^ ty_b[0];

    end_banner_renderer u_dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .game_won(game_won),
        .DrawX(DrawX), .DrawY(DrawY), .text_X(tx_a), .text_Y(ty_a),
        .text_pixel(tp_a), .banner_on(on_a), .banner_pixel(pix_a)
    );

    end_banner_renderer #(.SLIDE_STEP(5)) u_dut_step5 (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .game_won(game_won),
        .DrawX(DrawX), .DrawY(DrawY), .text_X(tx_b), .text_Y(ty_b),
        .text_pixel(tp_b), .banner_on(on_b), .banner_pixel(pix_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick();
        frame_clk = 1'b1;
        step();
        frame_clk = 1'b0;
        step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic probe(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
        step();
    endtask

    initial begin
        int bx_tab [8];
        int sweep_x [3];
        int sweep_y [3];
        int exp_blink;

        Reset     = 1'b1;
        frame_clk = 1'b0;
        game_won  = 1'b0;
        DrawX     = 10'd300;
        DrawY     = 10'd210;
        step();
        step();
        chk("reset_banner_on", on_a, 0);
        chk("reset_banner_pixel", pix_a, 0);

        // Released, game not won: banner stays off over the sweep.
        Reset = 1'b0;
        sweep_x = '{300, 301, 299};
        sweep_y = '{210, 211, 209};
        for (int i = 0; i < 3; i++) begin
            probe(sweep_x[i], sweep_y[i]);
            chk("idle_on", on_a, 0);
            chk("idle_pixel", pix_a, 0);
            chk("idle_text_x", tx_a, 0);
            chk("idle_text_y", ty_a, 0);
        end

        // Win: HIDDEN -> SLIDE with banner_y = 0.
        game_won = 1'b1;
        probe(296, 0);
        probe(296, 0);
        chk("slide_start_on", on_a, 1);

        tick();
        probe(296, 3);
        chk("slide1_above", on_a, 0);
        probe(296, 4);
        chk("slide1_top", on_a, 1);
        chk("slide1_text_y", ty_a, 0);

        ticks(40);  // 41 ticks total: step4 y=164, step5 y=205
        probe(296, 163);
        chk("slide41_a_above", on_a, 0);
        probe(296, 164);
        chk("slide41_a_top", on_a, 1);
        probe(296, 204);
        chk("slide41_b_above", on_b, 0);
        probe(296, 205);
        chk("slide41_b_top", on_b, 1);

        tick();     // 42: step5 clamps at 208
        probe(296, 207);
        chk("slide42_b_above", on_b, 0);
        probe(296, 208);
        chk("slide42_b_top", on_b, 1);
        probe(296, 167);
        chk("slide42_a_above", on_a, 0);

        ticks(10);  // 52: step4 reaches 208, HOLD
        probe(296, 207);
        chk("slide52_a_above", on_a, 0);
        probe(296, 208);
        chk("slide52_a_top", on_a, 1);

        // Glyph coordinate mapping at 2x scale.
        bx_tab = '{0, 0, 1, 1, 2, 2, 3, 3};
        for (int i = 0; i < 8; i++) begin
            probe(296 + i, 210);
            chk("hold_text_x", tx_a, bx_tab[i]);
            chk("hold_text_y", ty_a, 1);
            chk("hold_on", on_a, 1);
            chk("hold_pixel", pix_a, (bx_tab[i] % 2) ^ 1);
        end

        // Window edges.
        probe(343, 210);
        chk("edge_right_in", on_a, 1);
        chk("edge_right_text_x", tx_a, 23);
        probe(344, 210);
        chk("edge_right_out", on_a, 0);
        chk("edge_right_out_text_x", tx_a, 0);
        probe(296, 271);
        chk("edge_bottom_in", on_a, 1);
        chk("edge_bottom_text_y", ty_a, 31);
        probe(296, 272);
        chk("edge_bottom_out", on_a, 0);
        probe(295, 210);
        chk("edge_left_out", on_a, 0);

        // Hold for 60 frames, then blink 15 on / 15 off.
        ticks(59);
        probe(296, 210);
        chk("hold59_on", on_a, 1);
        probe(296, 207);
        chk("hold59_y_fixed", on_a, 0);
        tick();
        probe(296, 210);
        chk("blink_enter_on", on_a, 1);
        for (int t = 1; t <= 30; t++) begin
            tick();
            probe(296, 210);
            exp_blink = (t <= 14) ? 1 : ((t <= 29) ? 0 : 1);
            chk($sformatf("blink_t%0d", t), on_a, exp_blink);
        end

        // Reset in the middle of BLINK.
        Reset = 1'b1;
        probe(296, 210);
        chk("midreset_on", on_a, 0);
        chk("midreset_pixel", pix_a, 0);
        chk("midreset_text_x", tx_a, 0);
        Reset = 1'b0;
        probe(296, 0);
        chk("postreset_hidden_on", on_a, 0);
        probe(296, 0);
        chk("postreset_slide_on", on_a, 1);

        // Slide to banner_y = 100 then drop game_won on a frame tick.
        ticks(25);
        probe(296, 99);
        chk("slide100_above", on_a, 0);
        probe(296, 100);
        chk("slide100_top", on_a, 1);
        DrawX     = 10'd296;
        DrawY     = 10'd120;
        game_won  = 1'b0;
        frame_clk = 1'b1;
        step();
        chk("drop_same_cycle_on", on_a, 1);
        frame_clk = 1'b0;
        step();
        chk("drop_next_on", on_a, 0);
        chk("drop_next_pixel", pix_a, 0);

        // Re-assert: restart from banner_y = 0.
        game_won = 1'b1;
        probe(296, 0);
        chk("rewin_hidden_on", on_a, 0);
        probe(296, 0);
        chk("rewin_top", on_a, 1);
        probe(296, 63);
        chk("rewin_bottom_in", on_a, 1);
        chk("rewin_text_y", ty_a, 31);
        probe(296, 64);
        chk("rewin_bottom_out", on_a, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
